reg_bank_sweep: RTL and testbench

//  Parametrised successor to the 8x8 register bank: DEPTH x DATA_W storage with one write port and two

---
 rtl/reg_bank_sweep.sv | 129 ++++++++++++
 tb/tb_reg_bank_sweep.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_sweep.sv
// rtl/reg_bank_sweep.sv - DEPTH x DATA_W register bank, 1W/2R, registered reads, post-reset clear sweep
// Optional build macro: REGFILE_BYPASS_EN (same-cycle write-through to the read ports)
module reg_bank_sweep #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int DEPTH   = (1 << ADDR_W),
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addrw,
    input  logic [DATA_W-1:0] din,
    input  logic              write,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic              out_valid,
    output logic              busy
);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Extra bit so DEPTH == 2**ADDR_W is representable for range checks.
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic              HAS_R0   = (ZERO_R0 != 0);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_eff;
    logic [DATA_W-1:0]   rd1;
    logic [DATA_W-1:0]   rd2;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_X);
    endfunction

    function automatic logic is_r0(input logic [ADDR_W-1:0] a);
        return HAS_R0 && (a == '0);
    endfunction

    // State register; reset always restarts the sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Sweep finishes once the last entry has been zeroed.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR: if (clr_ptr == LAST_PTR) state_nxt = READY;
            READY: state_nxt = READY;
            default: state_nxt = CLEAR;
        endcase
    end

    assign busy = (state == CLEAR);

    // Sweep pointer advances one entry per clock while clearing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_ptr <= '0;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
        end
    end

    // A write lands only when ready, in range, and not aimed at a hardwired-zero entry 0.
    always_comb begin
        wr_eff = write && (state == READY) && in_range(addrw) && !is_r0(addrw);
    end

    // Storage: zeroed by the sweep, otherwise updated by effective writes; reset itself leaves it alone.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (wr_eff) begin
                mem[addrw] <= din;
            end
        end
    end

    // Read data selection per port: out-of-range and hardwired entry 0 read as zero.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (in_range(addr1) && !is_r0(addr1)) begin
            rd1 = mem[addr1];
`ifdef REGFILE_BYPASS_EN
            if (wr_eff && (addrw == addr1)) rd1 = din;
`endif
        end
        if (in_range(addr2) && !is_r0(addr2)) begin
            rd2 = mem[addr2];
`ifdef REGFILE_BYPASS_EN
            if (wr_eff && (addrw == addr2)) rd2 = din;
`endif
        end
    end

    // Registered read outputs; data holds when no read is captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out1      <= '0;
            out2      <= '0;
            out_valid <= 1'b0;
        end else if ((state == READY) && rd_en) begin
            out1      <= rd1;
            out2      <= rd2;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_bank_sweep.sv
// tb/tb_reg_bank_sweep.sv - scoreboard bench for reg_bank_sweep
module tb_reg_bank_sweep;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] addr1, addr2, addrw;
    logic       rd_en, write;
    logic [7:0] din;
    logic [7:0] out1, out2;
    logic       out_valid, busy;

    logic       zrst_n;
    logic [2:0] zaddr1, zaddr2, zaddrw;
    logic       zrd_en, zwrite;
    logic [7:0] zdin;
    logic [7:0] zout1, zout2;
    logic       zout_valid, zbusy;

    int total = 0;
    int bad   = 0;

    logic [15:0] expq  [$];
    logic [15:0] zexpq [$];

    always #5 clk = ~clk;

    reg_bank_sweep #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .addr1(addr1), .addr2(addr2), .rd_en(rd_en),
        .addrw(addrw), .din(din), .write(write), .out1(out1), .out2(out2),
        .out_valid(out_valid), .busy(busy)
    );

    reg_bank_sweep #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(1)) u_dut_z (
        .clk(clk), .rst_n(zrst_n), .addr1(zaddr1), .addr2(zaddr2), .rd_en(zrd_en),
        .addrw(zaddrw), .din(zdin), .write(zwrite), .out1(zout1), .out2(zout2),
        .out_valid(zout_valid), .busy(zbusy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Monitor: every presented output must match the oldest expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (expq.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                logic [15:0] e;
                e = expq.pop_front();
                check("rd_out1", {24'd0, out1}, {24'd0, e[15:8]});
                check("rd_out2", {24'd0, out2}, {24'd0, e[7:0]});
            end
        end
        if (zout_valid === 1'b1) begin
            if (zexpq.size() == 0) begin
                check("z_unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                logic [15:0] e;
                e = zexpq.pop_front();
                check("z_rd_out1", {24'd0, zout1}, {24'd0, e[15:8]});
                check("z_rd_out2", {24'd0, zout2}, {24'd0, e[7:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts clocks after release until busy drops, bounded.
    task automatic count_busy(input bit zdut, output int n);
        n = 0;
        while (((zdut ? zbusy : busy) === 1'b1) && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic do_read(input logic [2:0] a1, input logic [2:0] a2,
                           input logic [7:0] e1, input logic [7:0] e2);
        addr1 = a1; addr2 = a2; rd_en = 1'b1;
        expq.push_back({e1, e2});
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        addrw = a; din = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] t3_exp;
        rst_n = 1'b0; addr1 = 0; addr2 = 0; addrw = 0; din = 0; rd_en = 0; write = 0;
        zrst_n = 1'b0; zaddr1 = 0; zaddr2 = 0; zaddrw = 0; zdin = 0; zrd_en = 0; zwrite = 0;

        // T1 + T4: reset, then sweep with write/read attempts that must be ignored.
        tick(); tick();
        check("reset_busy", {31'd0, busy}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out1", {24'd0, out1}, 32'd0);
        check("reset_out2", {24'd0, out2}, 32'd0);
        rst_n = 1'b1;
        write = 1'b1; addrw = 3'd2; din = 8'hFF; rd_en = 1'b1; addr1 = 3'd2; addr2 = 3'd2;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL sweep_out_valid: got=%0b expected=0", out_valid);
            end
        end
        write = 1'b0; rd_en = 1'b0;
        check("sweep_len", n, 32'd8);
        for (int i = 0; i < 4; i++) begin
            do_read(3'(2 * i), 3'(2 * i + 1), 8'h00, 8'h00);
        end

        // T2: write/read and hold.
        do_write(3'd3, 8'hA5);
        do_write(3'd7, 8'h3C);
        do_read(3'd3, 3'd7, 8'hA5, 8'h3C);
        tick();
        check("hold_valid", {31'd0, out_valid}, 32'd0);
        check("hold_out1", {24'd0, out1}, 32'hA5);
        check("hold_out2", {24'd0, out2}, 32'h3C);

        // T3: same-cycle collision on port 1, same address on both ports after.
        do_write(3'd5, 8'h11);
`ifdef REGFILE_BYPASS_EN
        t3_exp = 8'h77;
`else
        t3_exp = 8'h11;
`endif
        addrw = 3'd5; din = 8'h77; write = 1'b1;
        do_read(3'd5, 3'd3, t3_exp, 8'hA5);
        write = 1'b0;
        do_read(3'd5, 3'd5, 8'h77, 8'h77);
        do_read(3'd1, 3'd0, 8'h00, 8'h00);

        // T5: reset at sweep cycle 4 restarts a full sweep.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0; tick();
        check("mid_reset_busy", {31'd0, busy}, 32'd1);
        check("mid_reset_out1", {24'd0, out1}, 32'd0);
        rst_n = 1'b1;
        count_busy(1'b0, n);
        check("resweep_len", n, 32'd8);
        do_read(3'd5, 3'd3, 8'h00, 8'h00);
        do_read(3'd7, 3'd2, 8'h00, 8'h00);

        // T6: hardwired-zero entry 0.
        tick(); zrst_n = 1'b1;
        count_busy(1'b1, n);
        check("z_sweep_len", n, 32'd8);
        zaddrw = 3'd0; zdin = 8'h55; zwrite = 1'b1; tick();
        zaddrw = 3'd1; zdin = 8'h66; tick();
        zwrite = 1'b0;
        zaddr1 = 3'd0; zaddr2 = 3'd0; zrd_en = 1'b1; zexpq.push_back({8'h00, 8'h00}); tick();
        zaddr1 = 3'd1; zaddr2 = 3'd0; zexpq.push_back({8'h66, 8'h00}); tick();
        zrd_en = 1'b0;

        tick(); tick();
        check("queue_drained", expq.size(), 32'd0);
        check("z_queue_drained", zexpq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
